// File: rtl/usb_rx_pkg.sv
// Shared types and default timing constants for the USB receive path.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } rx_timer_state_t;

    localparam int unsigned USB_BITS_PER_BYTE = 8;
    localparam int unsigned USB_CLKS_PER_BIT  = 8;
    localparam int unsigned USB_SAMPLE_PHASE  = 3;
    localparam int unsigned USB_MAX_RUN_BITS  = 7;

endpackage

// File: rtl/usb_rx_timing_ctrl.sv
// USB RX bit-timing controller: edge-aligned sample phase, data-bit counter and
// no-transition watchdog producing shift_enable / byte_received strobes.
module usb_rx_timing_ctrl
    import usb_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = USB_CLKS_PER_BIT,
    parameter int unsigned SAMPLE_PHASE = USB_SAMPLE_PHASE,
    parameter int unsigned MAX_RUN_BITS = USB_MAX_RUN_BITS
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       enable_timer,
    input  logic       d_edge,
    input  logic       stuff_detect,
    output logic       shift_enable,
    output logic       byte_received,
    output logic [2:0] bit_index,
    output logic       sync_error
);

    localparam int unsigned PhaseW = $clog2(CLKS_PER_BIT);

    localparam logic [PhaseW-1:0] PhaseSample = PhaseW'(SAMPLE_PHASE);
    localparam logic [PhaseW-1:0] PhaseLast   = PhaseW'(CLKS_PER_BIT - 1);
    localparam logic [PhaseW-1:0] PhaseOne    = PhaseW'(1);
    localparam logic [2:0]        RunMax      = 3'(MAX_RUN_BITS);
    localparam logic [2:0]        IdxLast     = 3'(USB_BITS_PER_BYTE - 1);

    rx_timer_state_t   state_q, state_d;
    logic [PhaseW-1:0] phase_q, phase_d;
    logic [2:0]        bit_index_q, bit_index_d;
    logic [2:0]        run_cnt_q, run_cnt_d;
    logic              byte_q, byte_d;
    logic              sync_err_q, sync_err_d;
    logic              sample;

    assign sample = (state_q == RUN) && (phase_q == PhaseSample);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_index_d = bit_index_q;
        run_cnt_d   = run_cnt_q;
        byte_d      = 1'b0;
        sync_err_d  = sync_err_q;

        if (!enable_timer) begin
            state_d     = IDLE;
            phase_d     = '0;
            bit_index_d = '0;
            run_cnt_d   = '0;
            sync_err_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d     = ARM;
                    phase_d     = '0;
                    bit_index_d = '0;
                    run_cnt_d   = '0;
                    sync_err_d  = 1'b0;
                end
                ARM: begin
                    phase_d     = '0;
                    bit_index_d = '0;
                    run_cnt_d   = '0;
                    sync_err_d  = 1'b0;
                    // The arming edge is phase 0 of the first bit.
                    if (d_edge) begin
                        state_d = RUN;
                        phase_d = PhaseOne;
                    end
                end
                RUN: begin
                    if (d_edge) begin
                        phase_d   = PhaseOne;
                        run_cnt_d = '0;
                    end else if (phase_q == PhaseLast) begin
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end

                    if (sample) begin
                        if (!d_edge && (run_cnt_q == RunMax)) begin
                            // Watchdog trip: this sample is discarded.
                            state_d    = ERR;
                            sync_err_d = 1'b1;
                        end else begin
                            if (!d_edge) begin
                                run_cnt_d = run_cnt_q + 1'b1;
                            end
                            if (!stuff_detect) begin
                                bit_index_d = bit_index_q + 1'b1;
                                byte_d      = (bit_index_q == IdxLast);
                            end
                        end
                    end
                end
                ERR: begin
                    sync_err_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            bit_index_q <= '0;
            run_cnt_q   <= '0;
            byte_q      <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_index_q <= bit_index_d;
            run_cnt_q   <= run_cnt_d;
            byte_q      <= byte_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign shift_enable  = sample;
    assign byte_received = byte_q;
    assign bit_index     = bit_index_q;
    assign sync_error    = sync_err_q;

endmodule

// File: doc/usb_rx_timing_ctrl.md
# usb_rx_timing_ctrl

Bit-timing controller for the USB receive path. It recovers bit boundaries from the edge detector and runs a per-bit sample-phase counter, a data-bit counter and a no-transition watchdog. From these it produces the single-cycle `shift_enable` strobe for the RX shift register and the `byte_received` strobe for the RX decoder FSM. It sits between the edge detector and bit-unstuffer on one side and the RX shift register and decoder on the other.

## Interface
- `CLKS_PER_BIT`, 8, clocks per USB bit period; legal range 2–16.
- `SAMPLE_PHASE`, 3, phase value at which the bit is sampled; must be less than `CLKS_PER_BIT`.
- `MAX_RUN_BITS`, 7, maximum consecutive samples with no transition before a sync error is raised.

- `clk`  in  1  system clock; single clock domain.
- `n_rst`  in  1  asynchronous, active-low reset.
- `enable_timer`  in  1  receive window active; level signal.
- `d_edge`  in  1  one-cycle pulse marking a transition on the D+/D- pair.
- `stuff_detect`  in  1  qualifies the current sample as a stuffed bit; only meaningful while `shift_enable` is 1.
- `shift_enable`  out  1  one-cycle sample strobe.
- `byte_received`  out  1  one-cycle pulse after the 8th counted data bit.
- `bit_index`  out  3  number of data bits counted in the current byte (0–7).
- `sync_error`  out  1  sticky loss-of-sync flag.

## Operation
- **State machine.** States are IDLE, ARM, RUN and ERR. Reset state is IDLE.
  - IDLE → ARM when `enable_timer` is 1.
  - ARM → RUN when `d_edge` is 1.
  - RUN → ERR when the watchdog trips.
  - Any state → IDLE in the cycle after `enable_timer` is 0. This has priority over every other transition.
- **In IDLE and ARM:** `phase`, `bit_index` and `run_cnt` are held at 0. `shift_enable`, `byte_received` and `sync_error` are 0. In IDLE, `sync_error` is also cleared.
- **Phase counter** (`$clog2(CLKS_PER_BIT)` bits; active in RUN):
  - If `d_edge` is 1, next `phase` is 1. The edge cycle counts as phase 0.
  - Otherwise `phase` increments, wrapping from `CLKS_PER_BIT-1` to 0.
  - The ARM→RUN edge loads `phase` = 1 the same way.
- **`shift_enable`.** Equals (state == RUN) && (`phase` == `SAMPLE_PHASE`). It is decoded from registered state only.
  - A `d_edge` in a sample cycle does not suppress that sample. It only re-aligns the following phase.
- **Bit counter.** On each sample with `stuff_detect` = 0, `bit_index` increments, wrapping 7 → 0.
  - On the 7 → 0 wrap, `byte_received` is registered high for exactly the next cycle.
  - On a sample with `stuff_detect` = 1, `bit_index` holds and no byte is counted.
- **Watchdog.** `run_cnt` (3 bits) counts samples since the last `d_edge`.
  - `d_edge` clears it to 0. The edge wins over a coincident sample.
  - If a sample occurs with `run_cnt` == `MAX_RUN_BITS` and no `d_edge`, next state is ERR and `sync_error` goes to 1.
  - That triggering sample is not counted: `bit_index` holds and `byte_received` is suppressed.
- **In ERR:** no `shift_enable` and counters are frozen. `sync_error` stays 1 until the return to IDLE.
- **Reset mid-packet:** all registers return to IDLE/0 immediately and asynchronously. There is no partial-byte recovery.

## Timing
- Edge in ARM at cycle t gives `phase` 1, 2, 3 at t+1, t+2, t+3.
- First `shift_enable` is at t+3 (default parameters). Subsequent samples follow every `CLKS_PER_BIT` cycles unless re-aligned.
- Re-alignment: `d_edge` at cycle e gives the next sample at e+`SAMPLE_PHASE`.
- `byte_received` latency is 1 cycle after the qualifying sample.
- `sync_error` latency is 1 cycle after the offending sample.
- `enable_timer` falling edge: outputs are 0 from the next cycle.
- Reset value of every output is 0.

## Structure
- Shared package `usb_rx_pkg` holds:
  - `rx_timer_state_t` enum (IDLE, ARM, RUN, ERR);
  - `USB_BITS_PER_BYTE` = 8;
  - default constants `USB_CLKS_PER_BIT` and `USB_SAMPLE_PHASE`.
- One `always_ff` block for state and counters, plus one `always_comb` block for next-state logic.
- No sub-module. The three counters have edge-driven loads that differ from a plain rollover counter, so they are written inline.

## Test plan
- **Single edge, no further edges.** Reset, `enable_timer` = 1, one `d_edge` at t, `stuff_detect` = 0.
  - `shift_enable` at t+3, t+11, …, t+51.
  - `bit_index` reaches 7.
  - The 8th sample at t+59 trips the watchdog: `sync_error` = 1 at t+60 and `byte_received` stays 0.
- **Byte with edges.** `d_edge` every 16 cycles, `stuff_detect` = 0.
  - Exactly one `byte_received` pulse, 1 cycle after the 8th sample.
  - `bit_index` returns to 0.
  - `sync_error` stays 0.
- **Re-alignment.** Inject `d_edge` at phase 6.
  - Next `shift_enable` occurs 3 cycles later, not at the nominal position.
- **Stuffed bit.** `stuff_detect` = 1 on the 4th sample.
  - `bit_index` holds at 3.
  - `byte_received` arrives one bit period (8 cycles) later than in the nominal case.
- **Window close.** Drop `enable_timer` mid-byte with `bit_index` = 5.
  - Next cycle: IDLE, `bit_index` = 0, no strobes.
  - Re-arm, then `d_edge`: first sample 3 cycles after the edge.
- **Async reset.** Assert `n_rst` low mid-byte, between clock edges.
  - All outputs are 0 immediately.
  - After release the block is in IDLE and ignores `d_edge` until `enable_timer` = 1.
